// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter
// Shares the single register-file write port between the ALU writeback path
// and the load-unit writeback path. Loads are buffered in a small in-order
// FIFO. Each cycle one winner is picked round-robin between the ALU request
// and the FIFO head, and its write is registered onto the write port.
//
// Ports:
//   clock, resetn                 core clock, asynchronous active-low reset
//   alu_valid/alu_ready           ALU writeback handshake
//   alu_rd, alu_data              ALU destination and result
//   ld_valid/ld_ready             load writeback handshake into the FIFO
//   ld_rd, ld_data                load destination and result
//   ld_fifo_count                 current FIFO occupancy
//   reg_wr_en, write_reg1,        registered register-file write port
//   write_data
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. ready never depends on the same port's valid, so a source may
// hold valid with stable payload until it sees ready.

module reg_wb_arbiter #(
  parameter int LD_FIFO_DEPTH = 4,
  localparam int AW = $clog2(LD_FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [4:0]    alu_rd,
  input  logic [31:0]   alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [4:0]    ld_rd,
  input  logic [31:0]   ld_data,
  output logic [CW-1:0] ld_fifo_count,
  output logic          reg_wr_en,
  output logic [4:0]    write_reg1,
  output logic [31:0]   write_data
);

  typedef enum logic {
    SRC_ALU  = 1'b0,
    SRC_LOAD = 1'b1
  } src_e;

  // FIFO storage and bookkeeping
  logic [4:0]    fifo_rd   [LD_FIFO_DEPTH];
  logic [31:0]   fifo_data [LD_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  src_e last_winner;

  logic fifo_empty;
  logic push;
  logic pop;
  logic alu_grant;
  logic grant_any;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;

  // Arbitration. The ALU is ready whenever it would win if it asked: either
  // nothing is queued, or the load side won last time. The FIFO head pops
  // when the ALU is not asking or it is the load side's turn. The two grants
  // are mutually exclusive by construction.
  always_comb begin
    fifo_empty = (count == '0);
    ld_ready   = (count < CW'(LD_FIFO_DEPTH));
    alu_ready  = fifo_empty || (last_winner == SRC_LOAD);
    pop        = !fifo_empty && (!alu_valid || (last_winner == SRC_ALU));
    alu_grant  = alu_valid && alu_ready;
    push       = ld_valid && ld_ready;
    grant_any  = alu_grant || pop;
    sel_rd     = alu_grant ? alu_rd   : fifo_rd[rd_ptr];
    sel_data   = alu_grant ? alu_data : fifo_data[rd_ptr];
  end

  assign ld_fifo_count = count;

  // Payload storage needs no reset; only the pointers and count define
  // which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= ld_rd;
      fifo_data[wr_ptr] <= ld_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two. A pushed
  // entry only becomes visible to the arbiter after the edge that stores it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Round-robin history: reset as LOAD so the ALU wins the first contention.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_winner <= SRC_LOAD;
    end else if (alu_grant) begin
      last_winner <= SRC_ALU;
    end else if (pop) begin
      last_winner <= SRC_LOAD;
    end
  end

  // Registered write port. A grant to x0 still consumes the slot but never
  // raises the write enable; address/data hold when nothing is granted.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      reg_wr_en  <= 1'b0;
      write_reg1 <= '0;
      write_data <= '0;
    end else if (grant_any) begin
      reg_wr_en  <= (sel_rd != 5'd0);
      write_reg1 <= sel_rd;
      write_data <= sel_data;
    end else begin
      reg_wr_en  <= 1'b0;
    end
  end

endmodule
